// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI monarch arbiter.
package spi_arb_pkg;

    // Width of a monarch command / response word
    localparam int SPI_CMD_W = 16;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    // Requester identity: 0 = inertial interface, 1 = IR/A2D interface
    typedef logic owner_t;

    localparam owner_t OWN_IMU = 1'b0;
    localparam owner_t OWN_A2D = 1'b1;

endpackage

// File: rtl/spi_arb_tmo.sv
// Transaction watchdog for the SPI arbiter.
// Cleared while a transaction is launched, counts every BUSY cycle, and
// flags the cycle in which the count reaches all-ones
// (the (2^TMO_W-1)-th BUSY cycle). Only built when SPI_ARB_TMO_EN is defined.
module spi_arb_tmo #(
    parameter int TMO_W = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Count value seen during the final allowed BUSY cycle
    localparam logic [TMO_W-1:0] LAST = ~TMO_W'(1);

    logic [TMO_W-1:0] cnt;

    // Busy-cycle counter: clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/spi_arb.sv
// Two-requester arbiter in front of a single 16-bit SPI monarch.
// Requester 0 is the inertial interface, requester 1 the IR/A2D interface.
// Grants one transaction at a time, drives the monarch wrt/wt_data
// handshake, steers SS_n to the owner's chip select and returns
// done/rd_data only to the owner. Ties are broken round-robin: the
// requester just served loses the next tie.
//
// Handshake: reqX is held high with a stable cmdX until doneX or errX
// pulses for one cycle; a req still high on the following cycle is a new
// request.
//
// Optional build macro SPI_ARB_TMO_EN: adds a BUSY-cycle watchdog that
// aborts a transaction with errX after 2^TMO_W-1 cycles. Without it, err0
// and err1 are tied low and BUSY only ends on spi_done.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int TMO_W     = 12,
    parameter bit RST_OWNER = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [SPI_CMD_W-1:0] cmd0,
    output logic                 done0,
    output logic                 err0,
    input  logic                 req1,
    input  logic [SPI_CMD_W-1:0] cmd1,
    output logic                 done1,
    output logic                 err1,
    output logic [SPI_CMD_W-1:0] rd_data,
    output logic                 busy,
    output logic                 wrt,
    output logic [SPI_CMD_W-1:0] wt_data,
    input  logic                 spi_done,
    input  logic [SPI_CMD_W-1:0] spi_rd_data,
    input  logic                 spi_SS_n,
    output logic                 SS0_n,
    output logic                 SS1_n
);

    state_t               state;
    owner_t               owner;
    owner_t               prio;
    owner_t               grant_id;
    logic [SPI_CMD_W-1:0] cmd_reg;
    logic                 tmo_hit;
    logic                 fin_ok;

`ifdef SPI_ARB_TMO_EN
    logic fin_tmo;

    spi_arb_tmo #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == LAUNCH),
        .en      (state == BUSY),
        .expired (tmo_hit)
    );

    // A real completion in the same cycle as the watchdog wins
    assign fin_tmo = (state == BUSY) && tmo_hit && !spi_done;
    assign err0    = fin_tmo && (owner == OWN_IMU);
    assign err1    = fin_tmo && (owner == OWN_A2D);
`else
    logic unused_tmo_w;

    assign unused_tmo_w = (TMO_W > 0);
    assign tmo_hit      = 1'b0;
    assign err0         = 1'b0;
    assign err1         = 1'b0;
`endif

    // Pick the winner among the requests currently high; prio breaks ties
    always_comb begin
        grant_id = prio;
        if (req0 && req1) begin
            grant_id = prio;
        end else if (req1) begin
            grant_id = OWN_A2D;
        end else begin
            grant_id = OWN_IMU;
        end
    end

    // Arbiter FSM: grant in IDLE, one LAUNCH cycle, wait in BUSY for done or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= OWN_IMU;
            prio    <= RST_OWNER;
            cmd_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner   <= grant_id;
                        cmd_reg <= (grant_id == OWN_A2D) ? cmd1 : cmd0;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // spi_done cannot legally arrive here, so it is not looked at
                    state <= BUSY;
                end
                BUSY: begin
                    if (spi_done || tmo_hit) begin
                        prio  <= ~owner;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion is reported in the same cycle the monarch pulses spi_done
    assign fin_ok  = (state == BUSY) && spi_done;
    assign done0   = fin_ok && (owner == OWN_IMU);
    assign done1   = fin_ok && (owner == OWN_A2D);
    assign rd_data = spi_rd_data;

    // Handshake and status decode straight from registered state
    assign wrt     = (state == LAUNCH);
    assign busy    = (state != IDLE);
    assign wt_data = cmd_reg;

    // Only the owner's chip select follows the monarch, and only while granted
    assign SS0_n = (busy && (owner == OWN_IMU)) ? spi_SS_n : 1'b1;
    assign SS1_n = (busy && (owner == OWN_A2D)) ? spi_SS_n : 1'b1;

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: two requester agents, a behavioural SPI
// monarch, and a scoreboard of expected transactions in grant order.
`timescale 1ns/1ps
module tb_spi_arb;

  localparam int TMO_W   = 4;
  localparam int TMO_CYC = (1 << TMO_W) - 1;

  localparam logic [3:0] K_D0 = 4'b1000;
  localparam logic [3:0] K_D1 = 4'b0100;
  localparam logic [3:0] K_E1 = 4'b0001;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] cmd0 = '0, cmd1 = '0;
  logic        done0, err0, done1, err1, busy, wrt;
  logic [15:0] rd_data, wt_data;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd_data = '0;
  logic        spi_SS_n = 1'b1;
  logic        SS0_n, SS1_n;

  spi_arb #(.TMO_W(TMO_W), .RST_OWNER(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .done0(done0), .err0(err0),
    .req1(req1), .cmd1(cmd1), .done1(done1), .err1(err1),
    .rd_data(rd_data), .busy(busy), .wrt(wrt), .wt_data(wt_data),
    .spi_done(spi_done), .spi_rd_data(spi_rd_data), .spi_SS_n(spi_SS_n),
    .SS0_n(SS0_n), .SS1_n(SS1_n)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave response the monarch model returns for a given command
  function automatic logic [15:0] rsp_of(input logic [15:0] cmd);
    if (cmd == 16'hA600) return 16'h00C3;
    return {cmd[7:0], cmd[15:8]} ^ 16'h0F0F;
  endfunction

  // Scoreboard entry: {pulse kind {done0,done1,err0,err1}, command, response}
  logic [35:0] exp_q[$];
  logic [15:0] q0[$], q1[$];

  function automatic logic own1(input logic [35:0] e);
    return e[34] | e[32];
  endfunction

  task automatic send(input bit id, input logic [15:0] cmd, input logic [3:0] kind);
    exp_q.push_back({kind, cmd, rsp_of(cmd)});
    if (id) q1.push_back(cmd);
    else    q0.push_back(cmd);
  endtask

  // ---------------- requester agents ----------------
  int rise0 = 0, rise1 = 0;

  initial begin : agents
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req0 && (done0 || err0)) begin
          if (q0.size() > 0) cmd0 = q0.pop_front();
          else               req0 = 1'b0;
        end else if (!req0 && q0.size() > 0) begin
          cmd0 = q0.pop_front(); req0 = 1'b1; rise0 = cyc;
        end
        if (req1 && (done1 || err1)) begin
          if (q1.size() > 0) cmd1 = q1.pop_front();
          else               req1 = 1'b0;
        end else if (!req1 && q1.size() > 0) begin
          cmd1 = q1.pop_front(); req1 = 1'b1; rise1 = cyc;
        end
      end
    end
  end

  // ---------------- SPI monarch model ----------------
  int spi_lat = 8;
  bit hang    = 1'b0;

  initial begin : spi_model
    int          mcnt;
    bit          active;
    logic [15:0] mcmd;
    mcnt = 0; active = 1'b0; mcmd = '0;
    forever begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      if (!rst_n) begin
        active = 1'b0; spi_SS_n = 1'b1;
      end else if (wrt) begin
        active = 1'b1; mcnt = 1; mcmd = wt_data; spi_SS_n = 1'b0;
      end else if (active && !hang) begin
        if (mcnt >= spi_lat) begin
          spi_done = 1'b1; spi_rd_data = rsp_of(mcmd); spi_SS_n = 1'b1; active = 1'b0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int wrt_cyc = 0;
  int last_done_cyc = -1;
  bit lat_chk = 1'b0;
  bit gap_chk = 1'b0;

  initial begin : monitor
    logic [35:0] cur;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wrt) begin
          if (exp_q.size() == 0) begin
            check_eq("unexp_wrt", wrt, 0);
          end else begin
            cur = exp_q[0];
            check_eq("wt_data", wt_data, cur[31:16]);
            if (lat_chk) begin
              check_eq("wrt_lat", cyc - (own1(cur) ? rise1 : rise0), 1);
              lat_chk = 1'b0;
            end
            if (gap_chk && last_done_cyc >= 0) check_eq("gap", cyc - last_done_cyc, 2);
          end
          wrt_cyc = cyc;
        end
        if (busy && exp_q.size() > 0) begin
          cur = exp_q[0];
          if (own1(cur)) begin
            check_eq("ss1_route", SS1_n, spi_SS_n);
            check_eq("ss0_quiet", SS0_n, 1);
          end else begin
            check_eq("ss0_route", SS0_n, spi_SS_n);
            check_eq("ss1_quiet", SS1_n, 1);
          end
        end else if (!busy) begin
          check_eq("ss_idle", {SS0_n, SS1_n}, 2'b11);
        end
        if (done0 || done1 || err0 || err1) begin
          if (exp_q.size() == 0) begin
            check_eq("unexp_pulse", {done0, done1, err0, err1}, 0);
          end else begin
            cur = exp_q.pop_front();
            check_eq("pulse_kind", {done0, done1, err0, err1}, cur[35:32]);
            if (done0 || done1) check_eq("rd_data", rd_data, cur[15:0]);
            if (err0 || err1)   check_eq("tmo_lat", cyc - wrt_cyc, TMO_CYC);
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk); n++;
    end
    check_eq("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      @(negedge clk); n++;
    end
    check_eq("busy_seen", busy, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [15:0] c;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wrt", wrt, 0);
    check_eq("rst_wt_data", wt_data, 16'h0000);
    check_eq("rst_pulses", {done0, done1, err0, err1}, 0);
    check_eq("rst_ss", {SS0_n, SS1_n}, 2'b11);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, 40-cycle slave
    spi_lat = 40; lat_chk = 1'b1;
    send(1'b0, 16'hA600, K_D0);
    wait_drain(200);

    // Simultaneous requests straight after reset: 0 first, then 1
    do_reset();
    spi_lat = 8; gap_chk = 1'b1; last_done_cyc = -1;
    send(1'b0, 16'hA600, K_D0);
    send(1'b1, 16'h1234, K_D1);
    wait_drain(100);

    // Fairness: both held for six transactions, grants alternate 0,1,...
    last_done_cyc = -1;
    for (int i = 0; i < 6; i++) begin
      c = 16'($urandom_range(0, 16'hFFFF));
      send(i[0], c, i[0] ? K_D1 : K_D0);
    end
    wait_drain(300);

    // Slave never answers requester 1; requester 0 queues up behind it
    last_done_cyc = -1; hang = 1'b1;
`ifdef SPI_ARB_TMO_EN
    send(1'b1, 16'hBEEF, K_E1);
`else
    send(1'b1, 16'hBEEF, K_D1);
`endif
    wait_busy(20);
    repeat (3) @(negedge clk);
    send(1'b0, 16'h5A5A, K_D0);
`ifdef SPI_ARB_TMO_EN
    n = 0;
    while (exp_q.size() > 1 && n < 40) begin
      @(negedge clk); n++;
    end
    check_eq("err_seen", exp_q.size(), 1);
`else
    repeat (40) @(negedge clk);
    check_eq("busy_hold", busy, 1);
    check_eq("err1_low", err1, 0);
`endif
    hang = 1'b0;
    wait_drain(100);
    gap_chk = 1'b0;

    // Reset in the middle of a transaction
    spi_lat = 30;
    send(1'b0, 16'hC0DE, K_D0);
    wait_busy(10);
    repeat (5) @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; q0.delete(); exp_q.delete();
    #1;
    check_eq("mid_rst_ss", {SS0_n, SS1_n}, 2'b11);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_wrt", wrt, 0);
    check_eq("mid_rst_pulses", {done0, done1, err0, err1}, 0);
    check_eq("mid_rst_wt_data", wt_data, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    spi_lat = 8;
    send(1'b1, 16'h0F1E, K_D1);
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Two-requester arbiter that time-shares one SPI_mnrch (16-bit, single-transaction) between the inertial interface (requester 0) and the IR/A2D interface (requester 1).
- Owns the monarch's wrt/wt_data handshake.
- Routes the monarch's SS_n to the chip select of the current owner.
- Returns done/rd_data to the owning requester only.
- Sits between the sensor interfaces and the single SPI_mnrch instance at top level.

Parameters:
- TMO_W, 12, width of the transaction timeout counter. A timeout fires after 2^TMO_W-1 BUSY cycles without spi_done.
- RST_OWNER, 0, requester that holds priority first after reset (0 or 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 wants a transaction; held until done0/err0
- cmd0  in  16  requester 0 command word; must be stable while req0 is high
- done0  out  1  1-clk pulse, requester 0 transaction complete, rd_data valid
- err0  out  1  1-clk pulse, requester 0 transaction aborted by timeout
- req1  in  1  as req0, requester 1
- cmd1  in  16  as cmd0
- done1  out  1  as done0
- err1  out  1  as err0
- rd_data  out  16  pass-through of spi_rd_data; valid only when done0/done1 is high
- busy  out  1  high from grant until return to IDLE
- wrt  out  1  to SPI_mnrch, start transaction
- wt_data  out  16  to SPI_mnrch, command word
- spi_done  in  1  from SPI_mnrch, transaction complete pulse
- spi_rd_data  in  16  from SPI_mnrch
- spi_SS_n  in  1  from SPI_mnrch
- SS0_n  out  1  chip select, inertial sensor
- SS1_n  out  1  chip select, A2D

Behaviour:
- Reset values: state=IDLE, owner=0, prio=RST_OWNER, cmd_reg=0. Outputs wrt=0, wt_data=0, done*/err*=0, busy=0, SS0_n=SS1_n=1.
- Reset asserted mid-transaction aborts immediately: no done or err pulse is issued, and both chip selects return to 1.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester indicated by prio.
  - On grant, latch cmd_reg<=cmdX and owner<=X, then go to LAUNCH.
- LAUNCH (1 cycle): wrt=1, then go to BUSY.
- wt_data=cmd_reg in every non-IDLE state; it holds its last value in IDLE.
- Latency: req sampled high in IDLE at cycle k, so wrt is high at cycle k+1.
- BUSY, spi_done=1:
  - doneX=1 that cycle (X=owner), with rd_data=spi_rd_data.
  - prio<=~owner.
  - Go to IDLE.
- BUSY, timeout counter reaches all-ones:
  - errX=1.
  - prio<=~owner.
  - Go to IDLE. A later spi_done is ignored while in IDLE.
- The timeout counter clears in LAUNCH and increments in BUSY.
- Round-robin: the requester just served always loses the next tie, so there is no starvation.
- A requester still holding req the cycle after done is treated as a new request.
  - It is granted only if the other requester is idle.
  - Minimum gap between transactions is 1 IDLE cycle.
- SS routing:
  - SS0_n = spi_SS_n when owner==0 and state!=IDLE, else 1.
  - SS1_n is the same for owner 1.
  - spi_SS_n high in IDLE is tolerated.
- busy=1 in LAUNCH and BUSY.
- spi_done arriving in LAUNCH is impossible by SPI_mnrch protocol and is ignored.
- req dropped while granted is ignored; the transaction completes and done is still pulsed.
- done0/done1/err0/err1 are mutually exclusive and are never high in the same cycle.

Optional Feature:
- Macro SPI_ARB_TMO_EN.
- Defined: timeout counter and err0/err1 behave as described above.
- Undefined:
  - Counter logic is not built.
  - err0/err1 are tied to 0.
  - BUSY exits only on spi_done.
  - TMO_W is unused.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum {IDLE, LAUNCH, BUSY}
  - owner encoding typedef (1 bit)
  - SPI_CMD_W=16 constant
- One natural sub-module: spi_arb_tmo.
  - Parameter TMO_W.
  - Inputs clr and en; output expired.
  - Instantiated only under SPI_ARB_TMO_EN.

Test Plan:
- Single request: req0=1, cmd0=16'hA600; SPI model returns 16'h00C3 after 40 clks -> wrt at k+1, wt_data=A600, SS0_n follows spi_SS_n, SS1_n=1, done0 one clk with rd_data=00C3.
- Simultaneous requests after reset (RST_OWNER=0): req0=req1=1, cmd0=A600, cmd1=1234 -> requester 0 served first; requester 1 wrt exactly 2 clks after done0 (IDLE, LAUNCH).
- Fairness: req0 and req1 held high continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; no done pulses overlap.
- Timeout (SPI_ARB_TMO_EN, TMO_W=4): req1=1, model never pulses spi_done -> err1 high exactly 15 BUSY cycles after LAUNCH; no done1; next grant goes to requester 0 if pending.
- Reset mid-transaction: assert rst_n=0 in BUSY -> SS0_n=SS1_n=1, busy=0, wrt=0 immediately; no done/err pulse; normal operation after release.
- Macro undefined: same stimulus as timeout test -> remains in BUSY indefinitely, err1 stays 0; a late spi_done yields done1.
